// File: rtl/vga_timing_if.sv
// vga_timing_if: bundles the raster-timing outputs of vga_timing_gen with
// its run enable.
//   en          - run enable, driven by the consumer (slave) side
//   pix_en      - one-clk pixel strobe
//   h_cnt/v_cnt - beam coordinates (10 bits each)
//   hsync/vsync - sync outputs to the connector
//   valid       - beam is inside the visible area
//   line_start  - one-clk pulse when a new line begins
//   frame_start - one-clk pulse when a new frame begins
//   frame_cnt   - frames since reset, wraps at 256
interface vga_timing_if;
  logic       en;
  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hsync;
  logic       vsync;
  logic       valid;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    input  en,
    output pix_en, h_cnt, v_cnt, hsync, vsync, valid,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  pix_en, h_cnt, v_cnt, hsync, vsync, valid,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (default 640x480@60 Hz from a
// 100 MHz clock with a divide-by-4 pixel enable).
// Ports:
//   clk - system clock
//   rst - asynchronous, active-high reset
//   vga - vga_timing_if.master: en in; pix_en, h_cnt, v_cnt, hsync, vsync,
//         valid, line_start, frame_start, frame_cnt out
// Every output is a register loaded from the next-state counters, so all
// decoded outputs line up with h_cnt/v_cnt on the same clk.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = ($clog2(CLK_DIV) < 2) ? 2 : $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [9:0]       h_reg, h_next;
  logic [9:0]       v_reg, v_next;
  logic [7:0]       frame_reg, frame_next;
  logic             adv, line_wrap, frame_wrap;
  logic             pix_en_reg, pix_en_next;
  logic             hsync_reg, hsync_next;
  logic             vsync_reg, vsync_next;
  logic             valid_reg, valid_next;
  logic             line_start_reg, frame_start_reg;

  always_comb begin
    div_next   = div_reg;
    h_next     = h_reg;
    v_next     = v_reg;
    frame_next = frame_reg;
    adv        = 1'b0;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;

    // The pixel advances on the enabled clk that ends the divider period.
    // Keying this off the divider (rather than the registered strobe) means
    // a freeze that lands on the last divider count still advances exactly
    // once when en returns.
    if (vga.en) begin
      if (div_reg == DIV_LAST) begin
        div_next = '0;
        adv      = 1'b1;
      end else begin
        div_next = div_reg + 1'b1;
      end
    end

    if (adv) begin
      if (h_reg == H_LAST) begin
        h_next    = '0;
        line_wrap = 1'b1;
        if (v_reg == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
          frame_next = frame_reg + 8'd1;
        end else begin
          v_next = v_reg + 10'd1;
        end
      end else begin
        h_next = h_reg + 10'd1;
      end
    end

    // Strobe is high for the whole clk in which the divider sits at its
    // last count while running.
    pix_en_next = vga.en && (div_next == DIV_LAST);
    valid_next  = (h_next < H_VIS_L) && (v_next < V_VIS_L);
    hsync_next  = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_next  = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg         <= '0;
      h_reg           <= '0;
      v_reg           <= '0;
      frame_reg       <= '0;
      pix_en_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      hsync_reg       <= ~SYNC_POL;
      vsync_reg       <= ~SYNC_POL;
      valid_reg       <= 1'b1;  // (0,0) is a visible pixel
    end else begin
      div_reg         <= div_next;
      h_reg           <= h_next;
      v_reg           <= v_next;
      frame_reg       <= frame_next;
      pix_en_reg      <= pix_en_next;
      line_start_reg  <= line_wrap;
      frame_start_reg <= frame_wrap;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      valid_reg       <= valid_next;
    end
  end

  assign vga.pix_en      = pix_en_reg;
  assign vga.h_cnt       = h_reg;
  assign vga.v_cnt       = v_reg;
  assign vga.hsync       = hsync_reg;
  assign vga.vsync       = vsync_reg;
  assign vga.valid       = valid_reg;
  assign vga.line_start  = line_start_reg;
  assign vga.frame_start = frame_start_reg;
  assign vga.frame_cnt   = frame_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen, using a small
// raster (8x6 pixels, divide-by-3) so that frame_cnt wrap is reachable.
// The stimulus process drives en / async rst and pushes the expected output
// vector; a separate monitor pops and compares after every clk edge and
// after every asynchronous reset assertion.
module tb_vga_timing_gen;
  localparam int CLK_DIV = 3;
  localparam int H_VIS = 4, H_FP = 1, H_SYNC = 2, H_BP = 1;
  localparam int V_VIS = 3, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam bit SYNC_POL = 1'b0;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;
  } obs_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   async_tgl = 1'b0;
  obs_t   exp_q[$];
  int     tests = 0;
  int     fails = 0;
  longint n = 0;   // enabled clk edges since the last reset

  vga_timing_if vif();

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(SYNC_POL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vif)
  );

  always #5 clk = ~clk;

  // Reference model: everything follows from the number of enabled clks
  // since reset. Pixels elapsed = cnt / CLK_DIV, and the beam position and
  // frame count are that pixel number split by line and frame size.
  function automatic obs_t predict(longint cnt, bit ran);
    obs_t   o;
    longint px;
    int     h, v;
    px = cnt / CLK_DIV;
    h  = int'(px % H_TOTAL);
    v  = int'((px / H_TOTAL) % V_TOTAL);
    o.pix_en      = ran && ((cnt % CLK_DIV) == CLK_DIV - 1);
    o.h           = 10'(h);
    o.v           = 10'(v);
    o.valid       = (h < H_VIS) && (v < V_VIS);
    o.hsync       = (h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
    o.vsync       = (v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
    o.line_start  = ran && ((cnt % CLK_DIV) == 0) && (h == 0);
    o.frame_start = o.line_start && (v == 0);
    o.frame_cnt   = 8'(px / (H_TOTAL * V_TOTAL));
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pix_en      = vif.pix_en;
    o.h           = vif.h_cnt;
    o.v           = vif.v_cnt;
    o.hsync       = vif.hsync;
    o.vsync       = vif.vsync;
    o.valid       = vif.valid;
    o.line_start  = vif.line_start;
    o.frame_start = vif.frame_start;
    o.frame_cnt   = vif.frame_cnt;
    return o;
  endfunction

  // Called at a negedge: drive en for the coming edge and queue its result.
  task automatic step(input bit en_val);
    vif.en = en_val;
    if (en_val) n = n + 1;
    exp_q.push_back(predict(n, en_val));
    @(negedge clk);
  endtask

  // Called at a negedge: pulse rst between clk edges; the monitor checks the
  // outputs while rst is still high, with no clk edge in between.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    n   = 0;
    exp_q.push_back(predict(0, 1'b0));
    async_tgl = ~async_tgl;
    #2;
    rst = 1'b0;
  endtask

  // Monitor
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk or async_tgl);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs t=%0t got pix=%b h=%0d v=%0d hs=%b vs=%b vld=%b ls=%b fs=%b fc=%0d required pix=%b h=%0d v=%0d hs=%b vs=%b vld=%b ls=%b fs=%b fc=%0d",
                   $time, a.pix_en, a.h, a.v, a.hsync, a.vsync, a.valid, a.line_start, a.frame_start, a.frame_cnt,
                   e.pix_en, e.h, e.v, e.hsync, e.vsync, e.valid, e.line_start, e.frame_start, e.frame_cnt);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    vif.en = 1'b0;
    @(negedge clk);
    do_reset();

    // Free run from reset
    repeat (20) step(1'b1);

    // Random enable gaps with occasional mid-frame resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 9) != 0);
    end

    // Long freeze at an arbitrary point, then resume
    repeat (37) step(1'b0);
    repeat (12) step(1'b1);

    // Reset while hsync is active on a non-zero line
    guard = 0;
    while (guard < 2000 &&
           !((((n / CLK_DIV) % H_TOTAL) >= H_VIS + H_FP) &&
             (((n / CLK_DIV) % H_TOTAL) <  H_VIS + H_FP + H_SYNC) &&
             (((n / CLK_DIV) / H_TOTAL) % V_TOTAL) > 0)) begin
      step(1'b1);
      guard++;
    end
    do_reset();
    repeat (20) step(1'b1);

    // Long run for frame_cnt wrap, with sparse enable gaps
    do_reset();
    for (int i = 0; i < 258 * H_TOTAL * V_TOTAL * CLK_DIV; i++)
      step($urandom_range(0, 49) != 0);
    repeat (5) step(1'b1);

    // Drain: every queued expectation must have been consumed
    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock.
- Produces the h_cnt/v_cnt beam coordinates consumed by the game display/draw_* pixel-address logic, plus hsync/vsync to the connector and a visible-area valid flag.
- Adds a per-frame tick and a frame counter for game-state animation pacing.

Parameters:
- CLK_DIV, 4: system clocks per pixel; pixel enable is one clk pulse every CLK_DIV clocks. Must be ≥2.
- H_VIS, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch; H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800.
- V_VIS, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch; V_TOTAL = 525.
- SYNC_POL, 0: sync active level; 0 means active-low.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: run enable; when low, all timing state freezes.
- pix_en, output, 1: one-clk pixel strobe.
- h_cnt, output, 10: horizontal pixel index, 0..H_TOTAL-1.
- v_cnt, output, 10: line index, 0..V_TOTAL-1.
- hsync, output, 1: horizontal sync.
- vsync, output, 1: vertical sync.
- valid, output, 1: high when the beam is in the visible area.
- line_start, output, 1: one-clk pulse on each new line.
- frame_start, output, 1: one-clk pulse on each new frame.
- frame_cnt, output, 8: frames since reset, wraps.

Behaviour:
- Reset (async, rst=1) forces:
  - divider=0, h_cnt=0, v_cnt=0, frame_cnt=0
  - pix_en=0, line_start=0, frame_start=0
  - hsync=vsync=~SYNC_POL (inactive)
  - valid=1, consistent with the (0,0) decode
- Divider: 2-bit-min counter, increments each clk while en=1, wraps at CLK_DIV-1. pix_en is registered high for exactly the clk after the divider reaches CLK_DIV-1, i.e. every 4th clk. Period is exactly CLK_DIV with no drift.
- Counter advance happens on a clk where pix_en=1 and en=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 on the same edge that h_cnt wraps.
- All remaining outputs are registered and computed from next-state counters, so every clk they match the current h_cnt/v_cnt with zero skew:
  - valid = (h_cnt<H_VIS) && (v_cnt<V_VIS)
  - hsync = SYNC_POL when H_VIS+H_FP ≤ h_cnt < H_VIS+H_FP+H_SYNC (656..751), else ~SYNC_POL
  - vsync = SYNC_POL when V_VIS+V_FP ≤ v_cnt < V_VIS+V_FP+V_SYNC (490..491), else ~SYNC_POL
- line_start pulses for 1 clk on the clk where h_cnt becomes 0 through a wrap.
- frame_start pulses for 1 clk where both counters become 0 through a wrap; line_start is also high on that clk.
- frame_cnt increments by 1 on the same clk as frame_start, mod 256 (255→0).
- Neither pulse is asserted on the reset release itself.
- en=0 holds the divider, counters, syncs and frame_cnt, and forces pix_en, line_start and frame_start to 0. Resuming en=1 continues from the held divider value; no pixel is skipped or duplicated.
- rst asserted mid-frame returns to the reset state immediately, without waiting for a clk edge. After release, the first pix_en is asserted in the CLK_DIV-th clk.
- Timing check: one frame = 800×525×4 = 1,680,000 clks, giving 59.52 Hz.
- Counter widths are fixed at 10 bits; no state is reachable outside the ranges above.

Test Plan:
- Reset then run 20 clks with en=1 → pix_en high at clks 4,8,12,16,20 only; h_cnt=5 after clk 20; v_cnt=0; hsync=vsync=1; valid=1.
- Run to h_cnt=639→640 → valid falls on the same clk as the h_cnt change. hsync goes low at h_cnt=656 and high at 752 (96 pixels = 384 clks). At 799→0: line_start pulses 1 clk and v_cnt=1.
- Run a full frame → vsync low exactly for v_cnt 490–491 (1600 pixel strobes). frame_start pulses once when (799,524)→(0,0). frame_cnt=1. Counted clks between frame_start pulses = 1,680,000.
- Hold en=0 for 37 clks at h_cnt=100 → no outputs change and no pulses appear. After en=1 the next pix_en comes after the remaining divider count; h_cnt reaches 101 with no skip.
- Preset/force 256 frames (or a shortened-parameter build with H_TOTAL=8, V_TOTAL=4) → frame_cnt wraps from 255 to 0 on frame_start.
- Assert rst asynchronously at h_cnt=700, v_cnt=300 (hsync low) → all outputs take reset values within the same cycle, without a clk edge. After release, the sequence matches the first scenario.
